// File: rtl/spi_boot_loader.sv
// ============================================================================
// Module  : spi_boot_loader
// Brief   : SPI-slave (mode 0) program loader driving the instruction-write
//           port of the memory controller; releases the CPU via booted.
// Option  : define SPI_BOOT_LOADER_CHECKSUM_EN for the running XOR checksum
//           and the 0x03 checksum-readback command.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_boot_loader #(
  parameter int Architecture    = 32,
  parameter int InstructionSize = 8 + Architecture,
  parameter int SyncStages      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sck,
  input  logic                       ss,
  input  logic                       mosi,
  output logic                       miso,
  output logic [Architecture-1:0]    writeInstructionAddress,
  output logic [InstructionSize-1:0] writeInstructionBuffer,
  output logic                       writeInstructionEnable,
  input  logic                       writeInstructionComplete,
  output logic                       booted,
  output logic                       error
);

  localparam int c_INSTR_BYTES = InstructionSize / 8;
  localparam int c_ADDR_BYTES  = Architecture / 8;

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_CMD    = 3'd1;
  localparam logic [2:0] c_ST_ADDR   = 3'd2;
  localparam logic [2:0] c_ST_DATA   = 3'd3;
  localparam logic [2:0] c_ST_IGNORE = 3'd4;

  localparam logic [0:0] c_W_IDLE = 1'b0;
  localparam logic [0:0] c_W_WAIT = 1'b1;

  localparam logic [7:0] c_CMD_POLL = 8'h00;
  localparam logic [7:0] c_CMD_LOAD = 8'h01;
  localparam logic [7:0] c_CMD_BOOT = 8'h02;
`ifdef SPI_BOOT_LOADER_CHECKSUM_EN
  localparam logic [7:0] c_CMD_CSUM = 8'h03;
`endif

  logic [SyncStages-1:0] r_sck_sync, r_ss_sync, r_mosi_sync;
  logic                  r_sck_d, r_ss_d;
  logic                  w_sck_s, w_ss_s, w_mosi_s;
  logic                  w_sck_rise, w_sck_fall, w_ss_fall, w_ss_active;

  logic [2:0]                 r_bitcnt;
  logic [6:0]                 r_rx_shift;
  logic [7:0]                 w_rx_byte;
  logic                       w_byte_done;
  logic [7:0]                 r_tx;
  logic [7:0]                 w_status;
  logic [7:0]                 w_tx_next;
  logic [3:0]                 w_nibble;

  logic [2:0]                 r_state, w_next_state;
  logic [7:0]                 r_byte_cnt;
  logic [Architecture-9:0]    r_addr_sr;
  logic [InstructionSize-1:0] r_hold;
  logic [InstructionSize-1:0] w_instr;
  logic [Architecture-1:0]    r_addr_ptr;
  logic                       r_ptr_reloaded;

  logic w_cmd_load, w_set_booted, w_set_badcmd, w_addr_done, w_data_byte, w_handoff;

  logic [0:0]                 r_wstate, w_next_wstate;
  logic                       w_start, w_wdone, w_overrun, w_pend_set;
  logic                       r_pend_valid;
  logic [InstructionSize-1:0] r_pend_buf;
  logic                       r_we;
  logic [InstructionSize-1:0] r_wbuf;
  logic [Architecture-1:0]    r_waddr;

  logic r_booted, r_badcmd, r_overrun;

  // ---------------------------------------------------------------- sync
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sck_sync  <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SyncStages-2:0], sck};
      r_ss_sync   <= {r_ss_sync[SyncStages-2:0], ss};
      r_mosi_sync <= {r_mosi_sync[SyncStages-2:0], mosi};
      r_sck_d     <= w_sck_s;
      r_ss_d      <= w_ss_s;
    end
  end

  assign w_sck_s     = r_sck_sync[SyncStages-1];
  assign w_ss_s      = r_ss_sync[SyncStages-1];
  assign w_mosi_s    = r_mosi_sync[SyncStages-1];
  assign w_sck_rise  = w_sck_s & ~r_sck_d;
  assign w_sck_fall  = ~w_sck_s & r_sck_d;
  assign w_ss_fall   = ~w_ss_s & r_ss_d;
  assign w_ss_active = ~w_ss_s;

  // ---------------------------------------------------------------- rx bits
  assign w_rx_byte   = {r_rx_shift, w_mosi_s};
  assign w_byte_done = w_ss_active & ~w_ss_fall & w_sck_rise & (r_bitcnt == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bitcnt   <= 3'd0;
      r_rx_shift <= 7'd0;
    end else if (!w_ss_active || w_ss_fall) begin
      r_bitcnt   <= 3'd0;
    end else if (w_sck_rise) begin
      r_rx_shift <= w_rx_byte[6:0];
      r_bitcnt   <= r_bitcnt + 3'd1;
    end
  end

  // ---------------------------------------------------------------- tx
  assign w_status = {r_booted, r_overrun, r_badcmd, r_we, w_nibble};

  // A byte-boundary load happens on the 8th rising edge; the following falling
  // edge must not shift, so shifting is gated by a non-zero bit count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx <= 8'd0;
    end else if (w_ss_fall) begin
      r_tx <= w_status;
    end else if (w_byte_done) begin
      r_tx <= w_tx_next;
    end else if (w_sck_fall && w_ss_active && (r_bitcnt != 3'd0)) begin
      r_tx <= {r_tx[6:0], 1'b0};
    end
  end

  assign miso = w_ss_active & r_tx[7];

  // ---------------------------------------------------------------- rx FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (!w_ss_active) begin
      w_next_state = c_ST_IDLE;
    end else if (w_ss_fall) begin
      w_next_state = c_ST_CMD;
    end else if (w_byte_done) begin
      case (r_state)
        c_ST_CMD:  w_next_state = w_cmd_load ? c_ST_ADDR : c_ST_IGNORE;
        c_ST_ADDR: if (w_addr_done) w_next_state = c_ST_DATA;
        default:   w_next_state = r_state;
      endcase
    end
  end

`ifdef SPI_BOOT_LOADER_CHECKSUM_EN
  logic w_csum_rsp;
`endif

  always_comb begin
    w_cmd_load   = 1'b0;
    w_set_booted = 1'b0;
    w_set_badcmd = 1'b0;
    w_addr_done  = 1'b0;
    w_data_byte  = 1'b0;
    w_handoff    = 1'b0;
`ifdef SPI_BOOT_LOADER_CHECKSUM_EN
    w_csum_rsp   = 1'b0;
`endif
    if (w_byte_done) begin
      case (r_state)
        c_ST_CMD: begin
          case (w_rx_byte)
            c_CMD_POLL: ;
            c_CMD_LOAD: begin
              if (r_booted) w_set_badcmd = 1'b1;
              else          w_cmd_load   = 1'b1;
            end
            c_CMD_BOOT: w_set_booted = 1'b1;
`ifdef SPI_BOOT_LOADER_CHECKSUM_EN
            c_CMD_CSUM: w_csum_rsp = 1'b1;
`endif
            default:    w_set_badcmd = 1'b1;
          endcase
        end
        c_ST_ADDR: w_addr_done = (r_byte_cnt == 8'(c_ADDR_BYTES - 1));
        c_ST_DATA: begin
          w_data_byte = 1'b1;
          w_handoff   = (r_byte_cnt == 8'(c_INSTR_BYTES - 1));
        end
        default: ;
      endcase
    end
  end

  assign w_instr = {r_hold[InstructionSize-9:0], w_rx_byte};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_cnt <= 8'd0;
      r_addr_sr  <= '0;
      r_hold     <= '0;
    end else begin
      if (!w_ss_active || w_ss_fall) begin
        r_byte_cnt <= 8'd0;
      end else if (w_byte_done) begin
        if (w_addr_done || w_handoff)                          r_byte_cnt <= 8'd0;
        else if (r_state == c_ST_ADDR || r_state == c_ST_DATA) r_byte_cnt <= r_byte_cnt + 8'd1;
        else                                                   r_byte_cnt <= 8'd0;
      end
      if (w_byte_done && r_state == c_ST_ADDR)
        r_addr_sr <= {r_addr_sr[Architecture-17:0], w_rx_byte};
      if (w_data_byte)
        r_hold <= w_instr;
    end
  end

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_wstate <= c_W_IDLE;
    else       r_wstate <= w_next_wstate;
  end

  always_comb begin
    w_next_wstate = r_wstate;
    case (r_wstate)
      c_W_IDLE: if (w_handoff || r_pend_valid)   w_next_wstate = c_W_WAIT;
      c_W_WAIT: if (writeInstructionComplete)     w_next_wstate = c_W_IDLE;
      default:                                    w_next_wstate = c_W_IDLE;
    endcase
  end

  always_comb begin
    w_start    = (r_wstate == c_W_IDLE) & (w_handoff | r_pend_valid);
    w_wdone    = (r_wstate == c_W_WAIT) & writeInstructionComplete;
    w_overrun  = (r_wstate == c_W_WAIT) & w_handoff & ~writeInstructionComplete;
    w_pend_set = (r_wstate == c_W_WAIT) & w_handoff & writeInstructionComplete;
  end

  // A reload during a pending write must not be disturbed by that write's
  // completion, so the increment is suppressed once the pointer was reloaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we           <= 1'b0;
      r_wbuf         <= '0;
      r_waddr        <= '0;
      r_pend_valid   <= 1'b0;
      r_pend_buf     <= '0;
      r_addr_ptr     <= '0;
      r_ptr_reloaded <= 1'b0;
    end else begin
      if (w_start) begin
        r_we         <= 1'b1;
        r_wbuf       <= r_pend_valid ? r_pend_buf : w_instr;
        r_waddr      <= r_addr_ptr;
        r_pend_valid <= 1'b0;
      end else if (w_wdone) begin
        r_we <= 1'b0;
      end
      if (w_pend_set) begin
        r_pend_valid <= 1'b1;
        r_pend_buf   <= w_instr;
      end
      if (w_addr_done)
        r_addr_ptr <= {r_addr_sr, w_rx_byte};
      else if (w_wdone && !r_ptr_reloaded)
        r_addr_ptr <= r_addr_ptr + Architecture'(1);
      if (w_addr_done)  r_ptr_reloaded <= 1'b1;
      else if (w_start) r_ptr_reloaded <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_booted  <= 1'b0;
      r_badcmd  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_set_booted) r_booted  <= 1'b1;
      if (w_set_badcmd) r_badcmd  <= 1'b1;
      if (w_overrun)    r_overrun <= 1'b1;
    end
  end

`ifdef SPI_BOOT_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic [7:0] w_buf_xor;

  always_comb begin
    w_buf_xor = 8'd0;
    for (int i = 0; i < c_INSTR_BYTES; i++)
      w_buf_xor = w_buf_xor ^ r_wbuf[i*8 +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_csum <= 8'd0;
    else if (w_cmd_load) r_csum <= 8'd0;
    else if (w_wdone)    r_csum <= r_csum ^ w_buf_xor;
  end

  assign w_nibble  = r_csum[3:0];
  assign w_tx_next = w_csum_rsp ? r_csum : w_status;
`else
  assign w_nibble  = 4'h0;
  assign w_tx_next = w_status;
`endif

  assign writeInstructionAddress = r_waddr;
  assign writeInstructionBuffer  = r_wbuf;
  assign writeInstructionEnable  = r_we;
  assign booted                  = r_booted;
  assign error                   = r_overrun | r_badcmd;

endmodule

`default_nettype wire

// File: tb/tb_spi_boot_loader.sv
// ============================================================================
// Module  : tb_spi_boot_loader
// Brief   : Self-checking bench for spi_boot_loader (SPI master model plus
//           memory-controller acknowledge responder).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sck = 1'b0;
  logic        ss = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [31:0] waddr;
  logic [39:0] wbuf;
  logic        we;
  logic        wc;
  logic        booted;
  logic        error;

  always #5 clk = ~clk;

  spi_boot_loader dut (
    .clk                      (clk),
    .reset                    (reset),
    .sck                      (sck),
    .ss                       (ss),
    .mosi                     (mosi),
    .miso                     (miso),
    .writeInstructionAddress  (waddr),
    .writeInstructionBuffer   (wbuf),
    .writeInstructionEnable   (we),
    .writeInstructionComplete (wc),
    .booted                   (booted),
    .error                    (error)
  );

  typedef struct {
    logic [31:0] a;
    logic [39:0] d;
  } wr_t;

  typedef struct {
    logic [31:0] start;
    int          n;
    logic [39:0] ins0;
    logic [39:0] ins1;
    logic [31:0] ea0;
    logic [31:0] ea1;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  bit         ack_en = 1'b1;
  wr_t        wq[$];
  logic [7:0] rxq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Acknowledges each write 3 cycles after enable rises and logs it.
  initial begin
    int          wait_cnt;
    logic [31:0] snap_a;
    logic [39:0] snap_d;
    wc = 1'b0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (wc) begin
        wc = 1'b0;
        chk("enable_dropped_after_complete", {63'd0, we}, 64'd0);
      end else if (ack_en && we) begin
        if (wait_cnt == 0) begin
          snap_a = waddr;
          snap_d = wbuf;
        end else begin
          chk("addr_stable", {32'd0, waddr}, {32'd0, snap_a});
          chk("buf_stable", {24'd0, wbuf}, {24'd0, snap_d});
        end
        wait_cnt++;
        if (wait_cnt == 3) begin
          wc = 1'b1;
          wait_cnt = 0;
          wq.push_back('{snap_a, snap_d});
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic spi_byte(input logic [7:0] tb, output logic [7:0] rb);
    for (int i = 7; i >= 0; i--) begin
      mosi = tb[i];
      #40;
      rb[i] = miso;
      sck = 1'b1;
      #80;
      sck = 1'b0;
      #40;
    end
  endtask

  task automatic frame(input logic [7:0] tx[$]);
    logic [7:0] r;
    rxq.delete();
    ss = 1'b0;
    #80;
    foreach (tx[i]) begin
      spi_byte(tx[i], r);
      rxq.push_back(r);
    end
    #80;
    ss = 1'b1;
    #160;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ss = 1'b1;
    sck = 1'b0;
    mosi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {31'd0, miso, we, booted, error, waddr}, 64'd0);
    chk("reset_buffer", {24'd0, wbuf}, 64'd0);
    reset = 1'b0;
    wq.delete();
    repeat (3) @(posedge clk);
  endtask

  task automatic push_word(ref logic [7:0] q[$], input logic [39:0] w, input int nb);
    for (int i = nb - 1; i >= 0; i--) q.push_back(8'((w >> (8 * i)) & 40'hFF));
  endtask

  initial begin
    vec_t       vt[3];
    logic [7:0] tx[$];

    vt[0] = '{32'h00000010, 1, 40'h1122334455, 40'h0000000000, 32'h00000010, 32'h00000000};
    vt[1] = '{32'hFFFFFFFF, 2, 40'hA1A2A3A4A5, 40'hB1B2B3B4B5, 32'hFFFFFFFF, 32'h00000000};
    vt[2] = '{32'h12345678, 2, 40'h0000000000, 40'hFFFFFFFFFF, 32'h12345678, 32'h12345679};

    // Idle reset and status poll
    do_reset();
    tx = {8'h00};
    frame(tx);
    chk("idle_poll_status", {56'd0, rxq[0]}, 64'h00);
    chk("miso_idle_ss_high", {63'd0, miso}, 64'd0);

    // Table-driven load frames
    for (int v = 0; v < 3; v++) begin
      do_reset();
      tx.delete();
      tx.push_back(8'h01);
      push_word(tx, {8'd0, vt[v].start}, 4);
      push_word(tx, vt[v].ins0, 5);
      if (vt[v].n == 2) push_word(tx, vt[v].ins1, 5);
      frame(tx);
      repeat (30) @(posedge clk);
      chk($sformatf("v%0d_cmd_status", v), {56'd0, rxq[0]}, 64'h00);
      chk($sformatf("v%0d_write_count", v), 64'(wq.size()), 64'(vt[v].n));
      if (wq.size() >= 1) begin
        chk($sformatf("v%0d_addr0", v), {32'd0, wq[0].a}, {32'd0, vt[v].ea0});
        chk($sformatf("v%0d_data0", v), {24'd0, wq[0].d}, {24'd0, vt[v].ins0});
      end
      if (vt[v].n == 2 && wq.size() >= 2) begin
        chk($sformatf("v%0d_addr1", v), {32'd0, wq[1].a}, {32'd0, vt[v].ea1});
        chk($sformatf("v%0d_data1", v), {24'd0, wq[1].d}, {24'd0, vt[v].ins1});
      end
      chk($sformatf("v%0d_no_error", v), {63'd0, error}, 64'd0);
    end

    // Partial instruction dropped on ss deassert
    do_reset();
    tx = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    frame(tx);
    repeat (30) @(posedge clk);
    chk("partial_no_write", 64'(wq.size()), 64'd0);
    tx = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    frame(tx);
    repeat (30) @(posedge clk);
    chk("refill_write_count", 64'(wq.size()), 64'd1);
    if (wq.size() >= 1) begin
      chk("refill_addr", {32'd0, wq[0].a}, 64'h0);
      chk("refill_data", {24'd0, wq[0].d}, 64'hAABBCCDDEE);
    end
`ifdef SPI_BOOT_LOADER_CHECKSUM_EN
    tx = {8'h00};
    frame(tx);
    chk("csum_status_nibble", {56'd0, rxq[0]}, 64'h0E);
    tx = {8'h03, 8'h00};
    frame(tx);
    chk("csum_readback", {56'd0, rxq[1]}, 64'hEE);
    chk("csum_cmd_ok", {63'd0, error}, 64'd0);
`else
    tx = {8'h03};
    frame(tx);
    chk("cmd03_is_bad", {63'd0, error}, 64'd1);
`endif

    // Overrun with acknowledge withheld, then reset mid-write
    do_reset();
    ack_en = 1'b0;
    tx.delete();
    tx.push_back(8'h01);
    push_word(tx, 40'h0000000100, 4);
    push_word(tx, 40'h0102030405, 5);
    push_word(tx, 40'h060708090A, 5);
    frame(tx);
    chk("ovr_enable_held", {63'd0, we}, 64'd1);
    chk("ovr_first_addr", {32'd0, waddr}, 64'h100);
    chk("ovr_first_data", {24'd0, wbuf}, 64'h0102030405);
    tx = {8'h00};
    frame(tx);
    chk("ovr_status", {56'd0, rxq[0]}, 64'h50);
    chk("ovr_error", {63'd0, error}, 64'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_drops_enable", {62'd0, we, error}, 64'd0);
    ack_en = 1'b1;
    do_reset();

    // Bad command, boot, then load refused
    tx = {8'h7E};
    frame(tx);
    chk("badcmd_error", {62'd0, error, booted}, 64'b10);
    tx = {8'h00};
    frame(tx);
    chk("badcmd_status", {56'd0, rxq[0]}, 64'h20);
    tx = {8'h02};
    frame(tx);
    chk("boot_set", {63'd0, booted}, 64'd1);
    tx = {8'h01, 8'h00, 8'h00, 8'h00, 8'h20, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    frame(tx);
    repeat (30) @(posedge clk);
    chk("booted_status", {56'd0, rxq[0]}, 64'hA0);
    chk("load_after_boot_no_write", 64'(wq.size()), 64'd0);
    chk("load_after_boot_enable", {62'd0, we, error}, 64'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
